// File: rtl/sm9_accumulator.sv
// Frame accumulator for 9-bit sign-magnitude operands with a sticky overflow flag.
// Define SM9_ACC_SAT_EN to saturate the magnitude on overflow; otherwise it wraps modulo 256.
module sm9_accumulator #(
    parameter int LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inValid,
    output logic       inReady,
    input  logic [8:0] inData,
    output logic       outValid,
    input  logic       outReady,
    output logic [8:0] outData,
    output logic       outOvf
);

    localparam int CNT_W = $clog2(LEN + 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [8:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             live;
    logic             fire;
    logic             last_beat;
    logic [8:0]       add_res;
    logic             add_ovf;
    logic [8:0]       mag_sum;
    logic [7:0]       mag;
    logic             sign;

    // Sign-magnitude add of acc and inData; a zero magnitude always gets a positive sign.
    always_comb begin
        mag_sum = {1'b0, acc[7:0]} + {1'b0, inData[7:0]};
        add_ovf = 1'b0;
        sign    = acc[8];
        mag     = acc[7:0];
        if (acc[8] == inData[8]) begin
            add_ovf = mag_sum[8];
`ifdef SM9_ACC_SAT_EN
            mag     = mag_sum[8] ? 8'hFF : mag_sum[7:0];
`else
            mag     = mag_sum[7:0];
`endif
        end else if (acc[7:0] < inData[7:0]) begin
            mag  = inData[7:0] - acc[7:0];
            sign = inData[8];
        end else begin
            mag  = acc[7:0] - inData[7:0];
            sign = acc[8];
        end
        add_res = {sign && (mag != 8'd0), mag};
    end

    assign fire      = inReady && inValid;
    assign last_beat = (cnt == CNT_W'(LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (fire) begin
                        state_next = last_beat ? DONE : ACC;
                    end
                end
                DONE: begin
                    if (outReady) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // live holds inReady low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= 9'd0;
            cnt  <= '0;
            ovf  <= 1'b0;
            live <= 1'b0;
        end else begin
            live <= 1'b1;
            if (clear || ((state == DONE) && outReady)) begin
                acc <= 9'd0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (fire) begin
                acc <= add_res;
                cnt <= cnt + CNT_W'(1);
                ovf <= ovf | add_ovf;
            end
        end
    end

    always_comb begin
        inReady  = live && (state != DONE);
        outValid = (state == DONE);
        outData  = (state == DONE) ? acc : 9'd0;
        outOvf   = (state == DONE) && ovf;
    end

endmodule

// File: tb/tb_sm9_accumulator.sv
// Bench for sm9_accumulator: three instances (LEN 4, 2, 1) share one stream and are scored
// against an integer-arithmetic model each cycle, plus directed checks of the key scenarios.
module tb_sm9_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [8:0] in_data;
    logic       out_ready;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] out_ovf;
    logic [8:0] out_data [3];

    int checks   = 0;
    int failures = 0;

    int len_of [3] = '{4, 2, 1};
    int m_acc  [3];
    int m_cnt  [3];
    bit m_ovf  [3];
    bit m_done [3];
    bit m_live [3];

    always #5 clk = ~clk;

    sm9_accumulator #(.LEN(4)) u_len4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .inValid(in_valid), .inReady(in_ready[0]),
        .inData(in_data), .outValid(out_valid[0]), .outReady(out_ready),
        .outData(out_data[0]), .outOvf(out_ovf[0])
    );

    sm9_accumulator #(.LEN(2)) u_len2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .inValid(in_valid), .inReady(in_ready[1]),
        .inData(in_data), .outValid(out_valid[1]), .outReady(out_ready),
        .outData(out_data[1]), .outOvf(out_ovf[1])
    );

    sm9_accumulator #(.LEN(1)) u_len1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .inValid(in_valid), .inReady(in_ready[2]),
        .inData(in_data), .outValid(out_valid[2]), .outReady(out_ready),
        .outData(out_data[2]), .outOvf(out_ovf[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [8:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
    endtask

    function automatic int smToInt(input logic [8:0] v);
        return v[8] ? -int'(v[7:0]) : int'(v[7:0]);
    endfunction

    function automatic logic [8:0] intToSm(input int v);
        if (v < 0) return {1'b1, 8'(-v)};
        return {1'b0, 8'(v)};
    endfunction

    // Reference model: signed integer sum per frame, clamped or wrapped when |sum| exceeds 255.
    always @(negedge clk) begin : model
        int s;
        int mag;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                checkOutput($sformatf("rst_valid%0d", i), out_valid[i], 0);
                checkOutput($sformatf("rst_ready%0d", i), in_ready[i], 0);
                checkOutput($sformatf("rst_data%0d", i), out_data[i], 0);
                checkOutput($sformatf("rst_ovf%0d", i), out_ovf[i], 0);
                m_acc[i]  = 0;
                m_cnt[i]  = 0;
                m_ovf[i]  = 0;
                m_done[i] = 0;
                m_live[i] = 0;
            end else begin
                checkOutput($sformatf("valid%0d", i), out_valid[i], m_done[i]);
                checkOutput($sformatf("ready%0d", i), in_ready[i], m_live[i] && !m_done[i]);
                if (m_done[i]) begin
                    checkOutput($sformatf("data%0d", i), out_data[i], intToSm(m_acc[i]));
                    checkOutput($sformatf("ovf%0d", i), out_ovf[i], m_ovf[i]);
                end
                if (clear || (m_done[i] && out_ready)) begin
                    m_acc[i]  = 0;
                    m_cnt[i]  = 0;
                    m_ovf[i]  = 0;
                    m_done[i] = 0;
                end else if (!m_done[i] && m_live[i] && in_valid) begin
                    s = m_acc[i] + smToInt(in_data);
                    if (s > 255 || s < -255) begin
                        m_ovf[i] = 1;
`ifdef SM9_ACC_SAT_EN
                        mag = 255;
`else
                        mag = (s < 0 ? -s : s) % 256;
`endif
                        s = (s < 0) ? -mag : mag;
                    end
                    m_acc[i] = s;
                    m_cnt[i]++;
                    if (m_cnt[i] == len_of[i]) m_done[i] = 1;
                end
                m_live[i] = 1;
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog: observed=timeout expected=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [8:0] d;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 9'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 checkOutput("ready_before_edge", in_ready[0], 0);
        applyStimulus(0, 9'h000, 0, 0);
        @(negedge clk);
        checkOutput("ready_after_edge", in_ready[0], 1);

        // Basic sum on LEN=4
        applyStimulus(0, 9'h000, 1, 1);
        applyStimulus(1, 9'h003, 1, 0);
        applyStimulus(1, 9'h005, 1, 0);
        applyStimulus(1, 9'h102, 1, 0);
        applyStimulus(1, 9'h00A, 1, 0);
        @(negedge clk);
        checkOutput("basic_early", out_valid[0], 0);
        applyStimulus(0, 9'h000, 1, 0);
        @(negedge clk);
        checkOutput("basic_valid", out_valid[0], 1);
        checkOutput("basic_data", out_data[0], 9'h010);
        checkOutput("basic_ovf", out_ovf[0], 0);
        applyStimulus(0, 9'h000, 1, 0);
        @(negedge clk);
        checkOutput("basic_drop", out_valid[0], 0);

        // Zero canonicalisation on LEN=2
        applyStimulus(0, 9'h000, 1, 1);
        applyStimulus(1, 9'h007, 1, 0);
        applyStimulus(1, 9'h107, 1, 0);
        applyStimulus(0, 9'h000, 1, 0);
        @(negedge clk);
        checkOutput("zero_valid", out_valid[1], 1);
        checkOutput("zero_data", out_data[1], 9'h000);

        // Overflow on LEN=2
        applyStimulus(0, 9'h000, 1, 1);
        applyStimulus(1, 9'h0C8, 1, 0);
        applyStimulus(1, 9'h064, 1, 0);
        applyStimulus(0, 9'h000, 1, 0);
        @(negedge clk);
`ifdef SM9_ACC_SAT_EN
        checkOutput("ovf_data", out_data[1], 9'h0FF);
`else
        checkOutput("ovf_data", out_data[1], 9'h02C);
`endif
        checkOutput("ovf_flag", out_ovf[1], 1);

        // Backpressure on LEN=1
        applyStimulus(0, 9'h000, 0, 1);
        applyStimulus(1, 9'h005, 0, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 9'($urandom), 0, 0);
            @(negedge clk);
            checkOutput("bp_valid", out_valid[2], 1);
            checkOutput("bp_data", out_data[2], 9'h005);
            checkOutput("bp_ready", in_ready[2], 0);
        end
        applyStimulus(0, 9'h000, 1, 0);
        @(negedge clk);
        checkOutput("bp_hold_last", out_valid[2], 1);
        applyStimulus(0, 9'h000, 1, 0);
        @(negedge clk);
        checkOutput("bp_released", out_valid[2], 0);
        checkOutput("bp_ready_back", in_ready[2], 1);

        // Clear mid-frame on LEN=4
        applyStimulus(0, 9'h000, 1, 1);
        applyStimulus(1, 9'h032, 1, 0);
        applyStimulus(1, 9'h03C, 1, 0);
        applyStimulus(1, 9'h001, 1, 1);
        applyStimulus(1, 9'h001, 1, 0);
        applyStimulus(1, 9'h002, 1, 0);
        applyStimulus(1, 9'h003, 1, 0);
        applyStimulus(1, 9'h004, 1, 0);
        applyStimulus(0, 9'h000, 1, 0);
        @(negedge clk);
        checkOutput("clr_valid", out_valid[0], 1);
        checkOutput("clr_data", out_data[0], 9'h00A);

        // Asynchronous reset while LEN=1 sits in DONE
        applyStimulus(0, 9'h000, 0, 1);
        applyStimulus(1, 9'h005, 0, 0);
        applyStimulus(0, 9'h000, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", out_valid[2], 0);
        checkOutput("arst_data", out_data[2], 0);
        checkOutput("arst_ovf", out_ovf[2], 0);
        checkOutput("arst_ready", in_ready[2], 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1, 9'h109, 1, 0);
        applyStimulus(0, 9'h000, 1, 0);
        @(negedge clk);
        checkOutput("arst_frame_valid", out_valid[2], 1);
        checkOutput("arst_frame_data", out_data[2], 9'h109);

        // Randomised traffic scored by the model
        repeat (600) begin
            d[8]   = 1'($urandom);
            d[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 49) == 0);
        end
        applyStimulus(0, 9'h000, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
